// File: rtl/bitplane_collect_1_8.sv
// ---------------------------------------------------------------------------
// bitplane_collect_1_8
//
// Collects eight consecutive bit-planes (each DW*9 bits wide) from a
// valid/ready input stream into eight output registers. When all eight
// planes are captured, the set is presented with OUT_VALID and held stable
// until the consumer releases it with OUT_READY.
//
// Parameters
//   DW         lane count; one plane is DW*9 bits
//   MSB_FIRST  0: planes arrive bit0..bit7, 1: planes arrive bit7..bit0
//
// Ports
//   CLK                  clock, rising edge
//   RST_N                asynchronous active-low reset
//   CLEAR                synchronous abort of the set being collected/held
//   REG_ARRAY_1152       incoming bit-plane
//   IN_VALID / IN_READY  input handshake (accept when both are 1)
//   REG_ARRAY_BIT0..7    registered bit-planes 0..7
//   OUT_VALID            all eight planes captured and stable
//   OUT_READY            consumer releases the held set
//   PLANE_IDX            plane register the next accepted plane lands in
// ---------------------------------------------------------------------------
module bitplane_collect_1_8 #(
    parameter int DW        = 128,
    parameter int MSB_FIRST = 0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            CLEAR,
    input  logic [DW*9-1:0] REG_ARRAY_1152,
    input  logic            IN_VALID,
    output logic            IN_READY,
    output logic [DW*9-1:0] REG_ARRAY_BIT0,
    output logic [DW*9-1:0] REG_ARRAY_BIT1,
    output logic [DW*9-1:0] REG_ARRAY_BIT2,
    output logic [DW*9-1:0] REG_ARRAY_BIT3,
    output logic [DW*9-1:0] REG_ARRAY_BIT4,
    output logic [DW*9-1:0] REG_ARRAY_BIT5,
    output logic [DW*9-1:0] REG_ARRAY_BIT6,
    output logic [DW*9-1:0] REG_ARRAY_BIT7,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [2:0]      PLANE_IDX
);

    localparam int PW = DW * 9;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t          state_q,     state_d;
    logic [2:0]      cnt_q,       cnt_d;
    logic [2:0]      plane_idx_q, plane_idx_d;
    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [PW-1:0]   plane_q [8];
    logic [PW-1:0]   plane_d [8];
    logic            accept_s;

    // Map the fill-order count to the physical plane register index.
    function automatic logic [2:0] fill_to_idx(input logic [2:0] c);
        if (MSB_FIRST != 0) begin
            return 3'd7 - c;
        end else begin
            return c;
        end
    endfunction

    // Handshake: a plane is taken only while the block advertises ready.
    always_comb begin
        accept_s = IN_VALID & in_ready_q & (state_q == ST_FILL);
    end

    // Next-state logic for FSM, fill counter, handshake flags and planes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        for (int i = 0; i < 8; i++) begin
            plane_d[i] = plane_q[i];
        end

        // CLEAR wins over both accept and release; planes keep their data.
        if (CLEAR) begin
            state_d     = ST_FILL;
            cnt_d       = 3'd0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept_s) begin
                        for (int i = 0; i < 8; i++) begin
                            if (3'(i) == plane_idx_q) begin
                                plane_d[i] = REG_ARRAY_1152;
                            end else begin
                                plane_d[i] = plane_q[i];
                            end
                        end
                        // 3-bit counter wraps to 0 on the eighth accept.
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_d     = ST_HOLD;
                            in_ready_d  = 1'b0;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d     = ST_FILL;
                            in_ready_d  = 1'b1;
                            out_valid_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_HOLD: begin
                    // Release edge only flips the FSM; no plane is taken.
                    if (OUT_READY) begin
                        state_d     = ST_FILL;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d     = ST_FILL;
                    cnt_d       = 3'd0;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            endcase
        end

        plane_idx_d = fill_to_idx(cnt_d);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_FILL;
            cnt_q       <= 3'd0;
            plane_idx_q <= (MSB_FIRST != 0) ? 3'd7 : 3'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                plane_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            plane_idx_q <= plane_idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < 8; i++) begin
                plane_q[i] <= plane_d[i];
            end
        end
    end

    assign IN_READY       = in_ready_q;
    assign OUT_VALID      = out_valid_q;
    assign PLANE_IDX      = plane_idx_q;
    assign REG_ARRAY_BIT0 = plane_q[0];
    assign REG_ARRAY_BIT1 = plane_q[1];
    assign REG_ARRAY_BIT2 = plane_q[2];
    assign REG_ARRAY_BIT3 = plane_q[3];
    assign REG_ARRAY_BIT4 = plane_q[4];
    assign REG_ARRAY_BIT5 = plane_q[5];
    assign REG_ARRAY_BIT6 = plane_q[6];
    assign REG_ARRAY_BIT7 = plane_q[7];

endmodule

// File: tb/tb_bitplane_collect_1_8.sv
// ---------------------------------------------------------------------------
// tb_bitplane_collect_1_8
//
// Two instances (LSB-first and MSB-first) share one stimulus stream. A
// queue-based model tracks the planes accepted in the current set; a compare
// process checks every output of both instances on each falling edge.
// ---------------------------------------------------------------------------
module tb_bitplane_collect_1_8;

    localparam int DW = 8;
    localparam int PW = DW * 9;

    logic          CLK;
    logic          RST_N;
    logic          CLEAR;
    logic [PW-1:0] din;
    logic          IN_VALID;
    logic          OUT_READY;

    logic          rdy0, rdy1, ov0, ov1;
    logic [2:0]    idx0, idx1;
    logic [PW-1:0] b0 [8];
    logic [PW-1:0] b1 [8];

    int n_checks = 0;
    int n_errors = 0;

    // Model: planes accepted in the current set, plus the stored registers.
    logic [PW-1:0] m_set [$];
    logic [PW-1:0] m_p0 [8];
    logic [PW-1:0] m_p1 [8];

    bitplane_collect_1_8 #(.DW(DW), .MSB_FIRST(0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .REG_ARRAY_1152(din),
        .IN_VALID(IN_VALID), .IN_READY(rdy0),
        .REG_ARRAY_BIT0(b0[0]), .REG_ARRAY_BIT1(b0[1]), .REG_ARRAY_BIT2(b0[2]),
        .REG_ARRAY_BIT3(b0[3]), .REG_ARRAY_BIT4(b0[4]), .REG_ARRAY_BIT5(b0[5]),
        .REG_ARRAY_BIT6(b0[6]), .REG_ARRAY_BIT7(b0[7]),
        .OUT_VALID(ov0), .OUT_READY(OUT_READY), .PLANE_IDX(idx0)
    );

    bitplane_collect_1_8 #(.DW(DW), .MSB_FIRST(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR), .REG_ARRAY_1152(din),
        .IN_VALID(IN_VALID), .IN_READY(rdy1),
        .REG_ARRAY_BIT0(b1[0]), .REG_ARRAY_BIT1(b1[1]), .REG_ARRAY_BIT2(b1[2]),
        .REG_ARRAY_BIT3(b1[3]), .REG_ARRAY_BIT4(b1[4]), .REG_ARRAY_BIT5(b1[5]),
        .REG_ARRAY_BIT6(b1[6]), .REG_ARRAY_BIT7(b1[7]),
        .OUT_VALID(ov1), .OUT_READY(OUT_READY), .PLANE_IDX(idx1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a set is full (held) when 8 planes have been accepted.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_set.delete();
            for (int i = 0; i < 8; i++) begin
                m_p0[i] = '0;
                m_p1[i] = '0;
            end
        end else if (CLEAR) begin
            m_set.delete();
        end else if (m_set.size() == 8) begin
            if (OUT_READY) m_set.delete();
        end else if (IN_VALID) begin
            m_p0[m_set.size()]     = din;
            m_p1[7 - m_set.size()] = din;
            m_set.push_back(din);
        end
    end

    // Compare process: every output of both instances against the model.
    always @(negedge CLK) begin
        int  n;
        logic full;
        n    = m_set.size();
        full = (n == 8);
        chk("in_ready0",  PW'(rdy0), PW'(!full));
        chk("in_ready1",  PW'(rdy1), PW'(!full));
        chk("out_valid0", PW'(ov0),  PW'(full));
        chk("out_valid1", PW'(ov1),  PW'(full));
        chk("plane_idx0", PW'(idx0), PW'(n % 8));
        chk("plane_idx1", PW'(idx1), PW'(7 - (n % 8)));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lsb_bit%0d", i), b0[i], m_p0[i]);
            chk($sformatf("msb_bit%0d", i), b1[i], m_p1[i]);
        end
    end

    function automatic logic [PW-1:0] rnd_plane();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] pat(input int k);
        return {DW{8'(k)}} ;
    endfunction

    // Drive one cycle of inputs at the falling edge.
    task automatic drive(input logic v, input logic [PW-1:0] d, input logic clr, input logic ordy);
        IN_VALID  = v;
        din       = d;
        CLEAR     = clr;
        OUT_READY = ordy;
        @(negedge CLK);
    endtask

    logic [PW-1:0] y, z, w;

    initial begin
        RST_N = 1'b0; CLEAR = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; din = '0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_idx0",   PW'(idx0), PW'(3'd0));
        chk("rst_idx1",   PW'(idx1), PW'(3'd7));
        chk("rst_ready0", PW'(rdy0), PW'(1'b1));
        chk("rst_valid0", PW'(ov0),  PW'(1'b0));
        RST_N = 1'b1;
        @(negedge CLK);

        // Eight planes with byte value k, back to back.
        for (int k = 0; k < 8; k++) begin
            if (k == 1) chk("msb_idx_seq", PW'(idx1), PW'(3'd6));
            drive(1'b1, pat(k), 1'b0, 1'b0);
        end
        chk("full_valid", PW'(ov0), PW'(1'b1));
        chk("full_ready", PW'(rdy0), PW'(1'b0));
        chk("lsb_bit3",   b0[3], {8{9'h0}} | pat(3));
        chk("lsb_bit7",   b0[7], pat(7));
        chk("msb_bit0",   b1[0], pat(7));
        chk("msb_bit6",   b1[6], pat(1));

        // Hold with IN_VALID asserted: nothing changes.
        for (int i = 0; i < 5; i++) drive(1'b1, rnd_plane(), 1'b0, 1'b0);
        chk("hold_bit0",  b0[0], pat(0));
        chk("hold_valid", PW'(ov0), PW'(1'b1));
        drive(1'b1, rnd_plane(), 1'b0, 1'b1);   // release edge, no accept
        chk("rel_valid",  PW'(ov0),  PW'(1'b0));
        chk("rel_idx0",   PW'(idx0), PW'(3'd0));
        chk("rel_bit0",   b0[0], pat(0));
        y = rnd_plane();
        drive(1'b1, y, 1'b0, 1'b0);
        chk("after_rel_bit0", b0[0], y);

        // Three more planes, then CLEAR alongside a valid plane.
        for (int i = 0; i < 2; i++) drive(1'b1, rnd_plane(), 1'b0, 1'b0);
        z = rnd_plane();
        drive(1'b1, z, 1'b1, 1'b0);
        chk("clr_idx0", PW'(idx0), PW'(3'd0));
        w = rnd_plane();
        drive(1'b1, w, 1'b0, 1'b0);
        chk("clr_next_bit0", b0[0], w);

        // Five planes, then asynchronous reset between edges.
        for (int i = 0; i < 4; i++) drive(1'b1, rnd_plane(), 1'b0, 1'b0);
        IN_VALID = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        chk("arst_bit0",  b0[0], '0);
        chk("arst_bit4",  b0[4], '0);
        chk("arst_msb7",  b1[7], '0);
        chk("arst_ready", PW'(rdy0), PW'(1'b1));
        chk("arst_idx1",  PW'(idx1), PW'(3'd7));
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Random traffic with gaps, occasional CLEAR and release.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0, rnd_plane(),
                  ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0);
        end
        drive(1'b0, '0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bitplane_collect_1_8.md
BITPLANE_COLLECT_1_8 -- requirements
Module: bitplane_collect_1_8

Interface
REQ-001 SHALL have parameter DW, default 128, meaning lane count; plane width is DW*9 bits.
REQ-002 SHALL have parameter MSB_FIRST, default 0, meaning 0 = planes arrive in order bit0..bit7 and 1 = planes arrive in order bit7..bit0.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 CLK  input  1  clock; all state changes on rising edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 CLEAR  input  1  synchronous abort of the current set.
REQ-007 REG_ARRAY_1152  input  DW*9  one incoming bit-plane.
REQ-008 IN_VALID  input  1  REG_ARRAY_1152 holds a valid plane.
REQ-009 IN_READY  output  1  block can accept a plane this cycle.
REQ-010 REG_ARRAY_BIT0..REG_ARRAY_BIT7  output  DW*9 each  registered bit-planes 0..7.
REQ-011 OUT_VALID  output  1  all 8 planes captured and stable.
REQ-012 OUT_READY  input  1  consumer releases the held set.
REQ-013 PLANE_IDX  output  3  bit-plane index the next accepted plane will be written to.

Function
REQ-014 SHALL implement FSM states FILL and HOLD only; reset state SHALL be FILL.
REQ-015 A plane SHALL be accepted only when IN_VALID=1 and IN_READY=1 on the same edge.
REQ-016 In FILL, IN_READY SHALL be 1 and OUT_VALID SHALL be 0; both outputs SHALL be driven from registered state.
REQ-017 On accept, REG_ARRAY_BIT[PLANE_IDX] SHALL load REG_ARRAY_1152; all other planes SHALL hold their values.
REQ-018 Fill-order counter cnt (3 bits) SHALL increment by 1 per accept.
REQ-019 PLANE_IDX SHALL equal cnt when MSB_FIRST=0, and 7-cnt when MSB_FIRST=1.
REQ-020 An accept at cnt=7 SHALL wrap cnt to 0 and move the FSM to HOLD.
REQ-021 OUT_VALID SHALL be 1 from the cycle after the 8th accept (latency 1 cycle).
REQ-022 In HOLD, IN_READY SHALL be 0 and REG_ARRAY_BIT0..7 SHALL be stable.
REQ-023 In HOLD with OUT_READY=1 at an edge, the FSM SHALL return to FILL, so OUT_VALID=0 and IN_READY=1 on the next cycle.
REQ-024 No plane SHALL be accepted on the release edge.
REQ-025 OUT_READY SHALL be ignored in FILL.
REQ-026 IN_VALID SHALL be ignored in HOLD.
REQ-027 CLEAR=1 SHALL force the FSM to FILL and cnt to 0 on that edge, in either state, and SHALL take priority over accept and release.
REQ-028 CLEAR SHALL not zero the plane registers.
REQ-029 Gaps in IN_VALID SHALL not disturb cnt or the stored planes.

Reset
REQ-030 RST_N=0 SHALL immediately, without waiting for CLK, set FSM=FILL, cnt=0, OUT_VALID=0, IN_READY=1 and all REG_ARRAY_BITk=0.
REQ-031 PLANE_IDX SHALL equal 0 during reset when MSB_FIRST=0, and 7 when MSB_FIRST=1.
REQ-032 Reset asserted mid-fill or in HOLD SHALL discard the partial set.
REQ-033 After RST_N deasserts, the first accept SHALL occur no earlier than the next rising edge.

Verification
REQ-034 MSB_FIRST=0; send planes with value k in every byte for k=0..7 on 8 consecutive cycles -> OUT_VALID=1 one cycle later, REG_ARRAY_BITk holds pattern k, IN_READY=0.
REQ-035 MSB_FIRST=1; send the same 8 planes -> PLANE_IDX sequence 7,6,...,0 and REG_ARRAY_BIT7 holds the first plane.
REQ-036 Hold OUT_READY=0 for 5 cycles with IN_VALID=1 -> outputs unchanged and no accept; then OUT_READY=1 -> next cycle OUT_VALID=0, PLANE_IDX=0, and the next plane goes to BIT0.
REQ-037 Send 3 planes, then pulse CLEAR alongside IN_VALID -> that plane is not written, cnt=0, and the next plane goes to BIT0.
REQ-038 Send 5 planes, then assert RST_N=0 between edges -> all outputs zero immediately and IN_READY=1.
REQ-039 Send IN_VALID with random gaps -> exactly 8 accepts before OUT_VALID, with planes matching the order sent.
